axis_packet_dispatch_vector: RTL
================================

# axis_packet_dispatch_vector

Packet-level round-robin dispatcher: takes one AXI-Stream input and steers each complete packet, unmodified, to exactly one of NUM AXI-Stream outputs. It is the stage directly upstream of a vector of stream consumers. Outputs that are not in use are disabled through a mask and tied off with the vector empty terminator. Packets are never split across outputs, and the per-port choice is locked from the first beat to the tlast beat.

## Interface
- NUM, 4: number of output streams, 2..16.
- CNT_W, 32: width of the status counters.
- clock  input  1  block clock; must be the same clock as the `aclk` of all attached interfaces.
- rst  input  1  reset, asynchronous, active-high.
- port_mask  input  NUM  bit k=1 enables master[k] as a dispatch target; sampled only at packet start.
- slaver  axi_stream_inf.slaver  interface  input packet stream (tdata/tkeep/tuser/tlast/tvalid/tready).
- master  axi_stream_inf.master [NUM-1:0]  interface  output packet streams.
- cur_port  output  $clog2(NUM)  index of the port holding, or last holding, the lock.
- pkt_cnt  output  CNT_W  packets fully dispatched (tlast handshakes on any master).
- drop_cnt  output  CNT_W  packets discarded; stays 0 unless AXIS_DISPATCH_DROP_EN is defined.

## Operation
- FSM states: IDLE, LOCK, BURST, DROP. DROP exists only with the macro.
- **IDLE**
  - slaver.tready=0; all master tvalid=0.
  - If slaver.tvalid && |port_mask: sel <= first enabled index at or after rr_ptr (cyclic search), then go to LOCK.
  - If slaver.tvalid && port_mask==0: go to DROP with the macro; stay in IDLE (stall) without it.
- **LOCK**
  - One cycle; the select register settles; outputs are the same as IDLE. Then go to BURST.
- **BURST**
  - Pure combinational pass-through to master[sel]: tdata/tkeep/tuser/tlast/tvalid copied, slaver.tready = master[sel].tready.
  - Every other master has tvalid=0 and its data fields driven 0.
  - On a handshake with tlast=1: pkt_cnt++, rr_ptr <= sel+1 (wraps NUM-1 -> 0), go to IDLE.
- **DROP**
  - slaver.tready=1; all master tvalid=0.
  - On a handshake with tlast=1: drop_cnt++, go to IDLE.
- Mask changes during BURST or DROP are ignored; the current packet always completes on its locked port.
- Counters saturate at all-ones and do not wrap.
- cur_port = sel.
- Reset values: state IDLE; sel=0; rr_ptr=0; pkt_cnt=0; drop_cnt=0; slaver.tready=0; all master tvalid=0.
- Reset asserted mid-packet returns the block to IDLE immediately. The remaining beats of that packet are then treated as a new packet by the upstream source; the block performs no recovery.

## Timing
- Per-packet overhead: 2 cycles (IDLE detect, LOCK) before the first beat can handshake. Beats then pass with 0 cycles of latency at up to 1 beat/cycle.
- A 1-beat packet (tlast on its first beat) occupies IDLE, LOCK, BURST: 3 cycles minimum.
- Back-to-back packets: the next packet's first beat can handshake no earlier than 3 cycles after the previous tlast handshake.
- master tvalid must never depend on master tready: tvalid follows only slaver.tvalid and the state.
- slaver.tready depends combinationally on master[sel].tready in BURST only.

## Configuration
- AXIS_DISPATCH_DROP_EN
  - Defined: a packet arriving while port_mask==0 is consumed at 1 beat/cycle in DROP and counted in drop_cnt.
  - Undefined: DROP state and drop logic are absent; drop_cnt is tied to 0; the input stalls (tready=0) until some port_mask bit is set.

## Test plan
- **Round-robin:** NUM=4, mask=4'b1111, 8 packets of 3 beats each, all tready=1 -> packets land on ports 0,1,2,3,0,1,2,3 with data intact; pkt_cnt=8.
- **Skip masked ports:** mask=4'b1010, 4 packets -> ports 1,3,1,3 receive them; master[0] and master[2] tvalid stay 0 throughout.
- **Mid-packet mask change:** mask changes from 4'b0001 to 4'b0010 during beat 2 of a 5-beat packet -> all 5 beats go to port 0; the next packet goes to port 1.
- **Backpressure:** master[sel].tready toggles 1,0,0,1 across beats -> slaver.tready mirrors it each cycle; no beat is lost or duplicated; tvalid/tdata are held while stalled.
- **Empty mask:** mask=0 with one 4-beat packet -> with the macro, 4 beats consumed and drop_cnt=1; without it, tready=0 indefinitely, then after mask=4'b0100 the packet goes to port 2.
- **Reset during BURST:** assert rst on beat 2 -> in the same cycle all master tvalid=0, slaver.tready=0; after release, state IDLE, rr_ptr=0, counters 0.

Source files
------------

// File: rtl/axis_packet_dispatch_vector.sv
// Packet-level round-robin dispatcher: one AXI-Stream input steered whole-packet to one of NUM outputs.
// Optional build macro AXIS_DISPATCH_DROP_EN adds discard of packets that arrive while port_mask is empty.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for tvalid; picks next enabled port round-robin
//   LOCK  | one settle cycle for the select register
//   BURST | pass-through of the locked packet to master[sel]
//   DROP  | packet consumed and discarded (macro builds only)

module axis_packet_dispatch_vector #(
   parameter int NUM    = 4,
   parameter int CNT_W  = 32,
   parameter int DATA_W = 32,
   parameter int USER_W = 1,
   localparam int KEEP_W = DATA_W / 8,
   localparam int IDX_W  = $clog2(NUM)
) (
   input  logic                              clock,
   input  logic                              rst,
   input  logic [NUM-1:0]                    port_mask,
   input  logic [DATA_W-1:0]                 slaver_tdata,
   input  logic [KEEP_W-1:0]                 slaver_tkeep,
   input  logic [USER_W-1:0]                 slaver_tuser,
   input  logic                              slaver_tlast,
   input  logic                              slaver_tvalid,
   output logic                              slaver_tready,
   output logic [NUM-1:0][DATA_W-1:0]        master_tdata,
   output logic [NUM-1:0][KEEP_W-1:0]        master_tkeep,
   output logic [NUM-1:0][USER_W-1:0]        master_tuser,
   output logic [NUM-1:0]                    master_tlast,
   output logic [NUM-1:0]                    master_tvalid,
   input  logic [NUM-1:0]                    master_tready,
   output logic [IDX_W-1:0]                  cur_port,
   output logic [CNT_W-1:0]                  pkt_cnt,
   output logic [CNT_W-1:0]                  drop_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK  = 2'd1,
      BURST = 2'd2
`ifdef AXIS_DISPATCH_DROP_EN
      , DROP = 2'd3
`endif
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] sel, rr_ptr, pick;
   logic [IDX_W:0]   cand;
   logic             found;
   logic             hs_last;

   assign hs_last  = slaver_tvalid && slaver_tready && slaver_tlast;
   assign cur_port = sel;

   // cyclic search for the first enabled port at or after rr_ptr
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM; i++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM))
            cand = cand - (IDX_W+1)'(NUM);
         if (!found && port_mask[cand[IDX_W-1:0]]) begin
            pick  = cand[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // master tvalid follows only slaver_tvalid and state, never master_tready
   always_comb begin
      state_nxt     = state;
      slaver_tready = 1'b0;
      master_tdata  = '0;
      master_tkeep  = '0;
      master_tuser  = '0;
      master_tlast  = '0;
      master_tvalid = '0;
      case (state)
         IDLE: begin
            if (slaver_tvalid) begin
               if (|port_mask)
                  state_nxt = LOCK;
`ifdef AXIS_DISPATCH_DROP_EN
               else
                  state_nxt = DROP;
`endif
            end
         end
         LOCK: state_nxt = BURST;
         BURST: begin
            master_tdata[sel]  = slaver_tdata;
            master_tkeep[sel]  = slaver_tkeep;
            master_tuser[sel]  = slaver_tuser;
            master_tlast[sel]  = slaver_tlast;
            master_tvalid[sel] = slaver_tvalid;
            slaver_tready      = master_tready[sel];
            if (slaver_tvalid && master_tready[sel] && slaver_tlast)
               state_nxt = IDLE;
         end
`ifdef AXIS_DISPATCH_DROP_EN
         DROP: begin
            slaver_tready = 1'b1;
            if (slaver_tvalid && slaver_tlast)
               state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sel     <= '0;
         rr_ptr  <= '0;
         pkt_cnt <= '0;
      end else begin
         if (state == IDLE && slaver_tvalid && |port_mask)
            sel <= pick;
         if (state == BURST && hs_last) begin
            rr_ptr <= (sel == IDX_W'(NUM-1)) ? '0 : sel + 1'b1;
            if (pkt_cnt != '1)
               pkt_cnt <= pkt_cnt + 1'b1;
         end
      end
   end

`ifdef AXIS_DISPATCH_DROP_EN
   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         drop_cnt <= '0;
      else if (state == DROP && hs_last && drop_cnt != '1)
         drop_cnt <= drop_cnt + 1'b1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule
